// File: rtl/exc_commit.sv
// Write-back commit stage: latches the MEM-stage instruction, resolves exceptions,
// interrupts and ERTN, and gates the architectural CSR/RF writes.
module exc_commit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_exc,
  input  logic        ms_ertn,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic        csr_crmd_ie,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        ws_allowin,
  output logic        ws_valid,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_pc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ws_flush,
  output logic [31:0] flush_target
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        ws_valid_q, ws_valid_d;
  logic [31:0] ws_pc_q;
  logic [4:0]  ws_exc_q;
  logic        ws_ertn_q;
  logic        ws_csr_we_q;
  logic [13:0] ws_csr_num_q;
  logic [31:0] ws_csr_wmask_q;
  logic [31:0] ws_csr_wvalue_q;
  logic        ws_rf_we_q;
  logic [4:0]  ws_rf_waddr_q;
  logic [31:0] ws_rf_wdata_q;

  logic accept;
  logic live;
  logic int_pending;
  logic ws_exc;

  // Interrupt outranks every synchronous exception; flag order follows ms_exc bit order.
  function automatic logic [5:0] ecode_sel(input logic intr, input logic [4:0] f);
    if (intr)      return 6'h00;
    else if (f[0]) return 6'h08;
    else if (f[1]) return 6'h0D;
    else if (f[2]) return 6'h0B;
    else if (f[3]) return 6'h0C;
    else if (f[4]) return 6'h09;
    else           return 6'h00;
  endfunction

  assign ws_allowin  = (state_q == RUN);
  assign ws_valid    = ws_valid_q;
  assign accept      = ms_to_ws_valid && ws_allowin;
  // Strobes are held low while reset is asserted, even if WB still holds a live entry.
  assign live        = ws_valid_q && !reset;
  assign int_pending = csr_crmd_ie && |(csr_estat_is & csr_ecfg_lie);
  assign ws_exc      = live && (int_pending || |ws_exc_q);

  assign wb_ex        = ws_exc;
  assign wb_pc        = ws_pc_q;
  assign wb_ecode     = ws_exc ? ecode_sel(int_pending, ws_exc_q) : 6'h00;
  assign wb_esubcode  = 9'h000;
  assign ertn_flush   = live && ws_ertn_q && !ws_exc;
  assign ws_flush     = wb_ex || ertn_flush;
  assign flush_target = wb_ex ? csr_eentry : (ertn_flush ? csr_era : 32'h0);

  assign csr_we     = live && ws_csr_we_q && !ws_exc;
  assign csr_num    = ws_csr_num_q;
  assign csr_wmask  = ws_csr_wmask_q;
  assign csr_wvalue = ws_csr_wvalue_q;
  assign rf_we      = live && ws_rf_we_q && !ws_exc;
  assign rf_waddr   = ws_rf_waddr_q;
  assign rf_wdata   = ws_rf_wdata_q;

  always_comb begin
    state_d    = state_q;
    ws_valid_d = accept && !ws_flush;
    case (state_q)
      RUN:     if (ws_flush) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      ws_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_valid_q <= ws_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ws_pc_q         <= ms_pc;
      ws_exc_q        <= ms_exc;
      ws_ertn_q       <= ms_ertn;
      ws_csr_we_q     <= ms_csr_we;
      ws_csr_num_q    <= ms_csr_num;
      ws_csr_wmask_q  <= ms_csr_wmask;
      ws_csr_wvalue_q <= ms_csr_wvalue;
      ws_rf_we_q      <= ms_rf_we;
      ws_rf_waddr_q   <= ms_rf_waddr;
      ws_rf_wdata_q   <= ms_rf_wdata;
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Bench for exc_commit: directed scenarios then random traffic, all checked
// against a slot-level model of the commit rules.
module tb_exc_commit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_exc;
  logic        ms_ertn;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask, ms_csr_wvalue;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic [12:0] csr_estat_is, csr_ecfg_lie;
  logic        csr_crmd_ie;
  logic [31:0] csr_eentry, csr_era;
  logic        ws_allowin, ws_valid, csr_we, rf_we, wb_ex, ertn_flush, ws_flush;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, rf_wdata, wb_pc, flush_target;
  logic [4:0]  rf_waddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the WB slot: what it holds and whether the previous cycle flushed.
  logic        m_valid = 1'b0, m_blocked = 1'b0;
  logic [31:0] m_pc;
  logic [4:0]  m_exc;
  logic        m_ertn, m_csr_we, m_rf_we;
  logic [13:0] m_csr_num;
  logic [31:0] m_csr_wmask, m_csr_wvalue, m_rf_wdata;
  logic [4:0]  m_rf_waddr;
  logic        e_flush;
  logic [4:0]  d_waddr;

  exc_commit dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_exc(ms_exc), .ms_ertn(ms_ertn), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .csr_estat_is(csr_estat_is),
    .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie), .csr_eentry(csr_eentry),
    .csr_era(csr_era), .ws_allowin(ws_allowin), .ws_valid(ws_valid), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .ws_flush(ws_flush),
    .flush_target(flush_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ms_to_ws_valid = 1'b0;
    ms_exc = 5'b0; ms_ertn = 1'b0; ms_csr_we = 1'b0; ms_rf_we = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] exc, input logic ertn,
                         input logic cwe, input logic rwe);
    ms_to_ws_valid = 1'b1;
    ms_pc = pc; ms_exc = exc; ms_ertn = ertn; ms_csr_we = cwe; ms_rf_we = rwe;
    ms_csr_num = 14'($urandom); ms_csr_wmask = $urandom; ms_csr_wvalue = $urandom;
    ms_rf_waddr = 5'($urandom); ms_rf_wdata = $urandom;
  endtask

  // Settle after the falling edge, then compare every output against the model.
  task automatic look();
    logic [7:0] codes [5];
    logic ip, ex, er;
    logic [5:0] ec;
    codes = '{8'h08, 8'h0D, 8'h0B, 8'h0C, 8'h09};
    #1;
    ip = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'h0);
    ex = !reset && m_valid && (ip || m_exc != 5'b0);
    ec = 6'h00;
    if (ex && !ip)
      for (int i = 4; i >= 0; i--) if (m_exc[i]) ec = codes[i][5:0];
    er = !reset && m_valid && m_ertn && !ex;
    e_flush = ex || er;
    chk("ws_allowin", 32'(ws_allowin), 32'(!m_blocked));
    chk("ws_valid", 32'(ws_valid), 32'(m_valid));
    chk("wb_ex", 32'(wb_ex), 32'(ex));
    chk("wb_ecode", 32'(wb_ecode), 32'(ec));
    chk("wb_esubcode", 32'(wb_esubcode), 32'h0);
    chk("ertn_flush", 32'(ertn_flush), 32'(er));
    chk("ws_flush", 32'(ws_flush), 32'(e_flush));
    chk("flush_target", flush_target, ex ? csr_eentry : (er ? csr_era : 32'h0));
    chk("csr_we", 32'(csr_we), 32'(!reset && m_valid && m_csr_we && !ex));
    chk("rf_we", 32'(rf_we), 32'(!reset && m_valid && m_rf_we && !ex));
    if (m_valid) chk("wb_pc", wb_pc, m_pc);
    if (csr_we) begin
      chk("csr_num", 32'(csr_num), 32'(m_csr_num));
      chk("csr_wmask", csr_wmask, m_csr_wmask);
      chk("csr_wvalue", csr_wvalue, m_csr_wvalue);
    end
    if (rf_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
      chk("rf_wdata", rf_wdata, m_rf_wdata);
    end
  endtask

  task automatic tick();
    logic acc, nv, nb;
    acc = ms_to_ws_valid && !m_blocked;
    if (acc) begin
      m_pc = ms_pc; m_exc = ms_exc; m_ertn = ms_ertn;
      m_csr_we = ms_csr_we; m_csr_num = ms_csr_num;
      m_csr_wmask = ms_csr_wmask; m_csr_wvalue = ms_csr_wvalue;
      m_rf_we = ms_rf_we; m_rf_waddr = ms_rf_waddr; m_rf_wdata = ms_rf_wdata;
    end
    nv = acc && !e_flush;
    nb = e_flush;
    if (reset) begin nv = 1'b0; nb = 1'b0; end
    @(posedge clk);
    m_valid = nv; m_blocked = nb;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ms_pc = 32'h0; ms_csr_num = 14'h0; ms_csr_wmask = 32'h0; ms_csr_wvalue = 32'h0;
    ms_rf_waddr = 5'h0; ms_rf_wdata = 32'h0;
    csr_estat_is = 13'h0; csr_ecfg_lie = 13'h0; csr_crmd_ie = 1'b0;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000200;
    @(negedge clk);
    look(); tick();
    look(); tick();
    reset = 1'b0;
    look();
    chk("reset_allowin", 32'(ws_allowin), 32'h1);
    chk("reset_valid", 32'(ws_valid), 32'h0);
    tick();

    // SYS exception
    present(32'h1c000100, 5'b00100, 1'b0, 1'b1, 1'b1);
    look(); tick();
    idle(); look();
    chk("sys_wb_ex", 32'(wb_ex), 32'h1);
    chk("sys_ecode", 32'(wb_ecode), 32'h0B);
    chk("sys_wb_pc", wb_pc, 32'h1c000100);
    chk("sys_target", flush_target, 32'h1c008000);
    tick();
    look(); chk("sys_allowin_lo", 32'(ws_allowin), 32'h0); tick();
    look(); chk("sys_allowin_hi", 32'(ws_allowin), 32'h1); tick();

    // INE outranks SYS and ALE; writes suppressed
    present(32'h1c000104, 5'b10110, 1'b0, 1'b1, 1'b1);
    look(); tick();
    idle(); look();
    chk("ine_ecode", 32'(wb_ecode), 32'h0D);
    chk("ine_csr_we", 32'(csr_we), 32'h0);
    chk("ine_rf_we", 32'(rf_we), 32'h0);
    tick();
    look(); tick();

    // Interrupt on a plain ADD, then same ADD with interrupts disabled
    csr_crmd_ie = 1'b1; csr_estat_is = 13'h800; csr_ecfg_lie = 13'h800;
    present(32'h1c000108, 5'b0, 1'b0, 1'b0, 1'b1);
    look(); tick();
    idle(); look();
    chk("int_wb_ex", 32'(wb_ex), 32'h1);
    chk("int_ecode", 32'(wb_ecode), 32'h00);
    chk("int_rf_we", 32'(rf_we), 32'h0);
    tick();
    look(); tick();
    csr_crmd_ie = 1'b0;
    present(32'h1c00010c, 5'b0, 1'b0, 1'b0, 1'b1);
    d_waddr = ms_rf_waddr;
    look(); tick();
    idle(); look();
    chk("noint_wb_ex", 32'(wb_ex), 32'h0);
    chk("noint_rf_we", 32'(rf_we), 32'h1);
    chk("noint_waddr", 32'(rf_waddr), 32'(d_waddr));
    tick();

    // ERTN, then ERTN carrying INE
    present(32'h1c000110, 5'b0, 1'b1, 1'b0, 1'b0);
    look(); tick();
    idle(); look();
    chk("ertn_flush", 32'(ertn_flush), 32'h1);
    chk("ertn_target", flush_target, 32'h1c000200);
    chk("ertn_wb_ex", 32'(wb_ex), 32'h0);
    tick();
    look(); tick();
    present(32'h1c000114, 5'b00010, 1'b1, 1'b0, 1'b0);
    look(); tick();
    idle(); look();
    chk("ertn_ine_ex", 32'(wb_ex), 32'h1);
    chk("ertn_ine_ertn", 32'(ertn_flush), 32'h0);
    tick();
    look(); tick();

    // Back-to-back: BRK flushes the next two, fourth commits
    present(32'h1c000120, 5'b01000, 1'b0, 1'b0, 1'b1);
    look(); tick();
    present(32'h1c000124, 5'b0, 1'b0, 1'b0, 1'b1);
    look(); chk("b2b_brk_ecode", 32'(wb_ecode), 32'h0C); tick();
    present(32'h1c000128, 5'b0, 1'b0, 1'b0, 1'b1);
    look(); chk("b2b_second_drop", 32'(ws_valid), 32'h0); tick();
    present(32'h1c00012c, 5'b0, 1'b0, 1'b0, 1'b1);
    d_waddr = ms_rf_waddr;
    look();
    chk("b2b_third_drop", 32'(ws_valid), 32'h0);
    chk("b2b_allowin", 32'(ws_allowin), 32'h1);
    tick();
    idle(); look();
    chk("b2b_fourth_rf_we", 32'(rf_we), 32'h1);
    chk("b2b_fourth_waddr", 32'(rf_waddr), 32'(d_waddr));
    chk("b2b_fourth_pc", wb_pc, 32'h1c00012c);
    tick();

    // Reset while in FLUSH
    present(32'h1c000130, 5'b00001, 1'b0, 1'b0, 1'b0);
    look(); tick();
    idle(); look(); tick();
    reset = 1'b1;
    look(); chk("rstfl_in_flush", 32'(ws_allowin), 32'h0); tick();
    reset = 1'b0;
    look();
    chk("rstfl_allowin", 32'(ws_allowin), 32'h1);
    chk("rstfl_valid", 32'(ws_valid), 32'h0);
    chk("rstfl_strobes", {28'h0, csr_we, rf_we, wb_ex, ertn_flush}, 32'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7)
        present($urandom, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0,
                ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
      else
        idle();
      csr_crmd_ie  = ($urandom_range(0, 4) == 0);
      csr_estat_is = 13'($urandom);
      csr_ecfg_lie = 13'($urandom);
      csr_eentry   = $urandom;
      csr_era      = $urandom;
      look(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
